// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program-memory arbiter.
// addr_t / data_t mirror the project-wide definitions (4-bit physical
// address, 8-bit raw data word).
package mem_arb_pkg;

    typedef logic [3:0] addr_t;
    typedef logic [7:0] data_t;

    // Width of the wait-state down-counter (WAIT_STATES is 0..3).
    localparam int WAIT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DBG   = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way request picker: fixed fetch priority or round-robin, with an
// optional debug lock that shuts fetch out entirely. Purely combinational.
// gnt_o is one-hot or zero: bit 0 = fetch, bit 1 = debug.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       f_req_i,
    input  logic       d_req_i,
    input  owner_e     last_owner_i,
    input  logic       fetch_prio_i,
    input  logic       lock_i,
    output logic [1:0] gnt_o
);

    // Pick at most one requester.
    always_comb begin
        gnt_o = 2'b00;
        if (lock_i) begin
            gnt_o[1] = d_req_i;
        end else if (f_req_i && d_req_i) begin
            // On a conflict in round-robin mode the port that did not win last time goes.
            if (fetch_prio_i || (last_owner_i == OWN_DBG)) begin
                gnt_o[0] = 1'b1;
            end else begin
                gnt_o[1] = 1'b1;
            end
        end else begin
            gnt_o[0] = f_req_i;
            gnt_o[1] = d_req_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Program-memory arbiter between the instruction-fetch unit and the debug
// port. Grants are combinational at decision points (IDLE or RESP); the
// address is registered, read data is captured after WAIT_STATES extra
// cycles and returned with a one-cycle rvalid pulse.
//
// Optional feature: define MEM_ARB_LOCK_EN to enable the debug bus lock
// (d_lock). Without it d_lock is accepted but ignored.
//
// state  | meaning
// IDLE   | no access in flight, grant decision point
// ACCESS | address driven, wait counter running
// RESP   | rvalid cycle, grant decision point (back-to-back)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int FETCH_PRIO  = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  f_req,
    input  addr_t f_addr,
    output logic  f_gnt,
    output logic  f_rvalid,
    output data_t f_rdata,
    input  logic  d_req,
    input  addr_t d_addr,
    output logic  d_gnt,
    output logic  d_rvalid,
    output data_t d_rdata,
    input  logic  d_lock,
    output addr_t mem_addr,
    input  data_t mem_data,
    output logic  busy
);

    state_e              state_q;
    owner_e              owner_q;
    owner_e              last_owner_q;
    logic [WAIT_W-1:0]   cnt_q;
    addr_t               mem_addr_q;
    addr_t               mem_addr_d;
    data_t               f_rdata_q;
    data_t               d_rdata_q;
    logic                f_rvalid_q;
    logic                d_rvalid_q;
    logic                busy_q;
    logic                decide;
    logic                lock_act;
    logic [1:0]          pick;
    logic [1:0]          gnt;

    assign decide = (state_q == ST_IDLE) || (state_q == ST_RESP);

`ifdef MEM_ARB_LOCK_EN
    logic lock_q;

    // The lock is only honoured while d_lock is still high, so fetch can win
    // in the very cycle the lock is released.
    assign lock_act = lock_q && d_lock;

    // Enter lock on a debug grant with d_lock set; leave at the first decision point with d_lock low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (decide) begin
            if (!d_lock) begin
                lock_q <= 1'b0;
            end else if (gnt[1]) begin
                lock_q <= 1'b1;
            end
        end
    end
`else
    logic unused_d_lock;

    assign unused_d_lock = d_lock;
    assign lock_act      = 1'b0;
`endif

    mem_arb_rr u_rr (
        .f_req_i      (f_req),
        .d_req_i      (d_req),
        .last_owner_i (last_owner_q),
        .fetch_prio_i (FETCH_PRIO != 0),
        .lock_i       (lock_act),
        .gnt_o        (pick)
    );

    assign gnt        = decide ? pick : 2'b00;
    assign f_gnt      = gnt[0];
    assign d_gnt      = gnt[1];
    assign mem_addr_d = gnt[0] ? f_addr : d_addr;

    // Access sequencer: grant -> ACCESS (count down wait states) -> RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            last_owner_q <= OWN_DBG;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (gnt != 2'b00) begin
                        mem_addr_q   <= mem_addr_d;
                        owner_q      <= gnt[0] ? OWN_FETCH : OWN_DBG;
                        last_owner_q <= gnt[0] ? OWN_FETCH : OWN_DBG;
                        cnt_q        <= WAIT_W'(WAIT_STATES);
                        state_q      <= ST_ACCESS;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (owner_q == OWN_FETCH) begin
                            f_rdata_q  <= mem_data;
                            f_rvalid_q <= 1'b1;
                        end else begin
                            d_rdata_q  <= mem_data;
                            d_rvalid_q <= 1'b1;
                        end
                        state_q <= ST_RESP;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign f_rdata  = f_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign f_rvalid = f_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign busy     = busy_q;

    // A pending (not yet granted) request must keep its address stable.
    a_f_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (f_req && !f_gnt) |=> (!f_req || (f_addr == $past(f_addr))));

    a_d_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (d_req && !d_gnt) |=> (!d_req || (d_addr == $past(d_addr))));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Three instances:
//   0: WAIT_STATES=0, FETCH_PRIO=1
//   1: WAIT_STATES=0, FETCH_PRIO=0 (round-robin)
//   2: WAIT_STATES=2, FETCH_PRIO=1
// Each has its own request inputs and a combinational program image.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;

    logic  f_req    [3];
    addr_t f_addr   [3];
    logic  f_gnt    [3];
    logic  f_rvalid [3];
    data_t f_rdata  [3];
    logic  d_req    [3];
    addr_t d_addr   [3];
    logic  d_gnt    [3];
    logic  d_rvalid [3];
    data_t d_rdata  [3];
    logic  d_lock   [3];
    addr_t mem_addr [3];
    data_t mem_data [3];
    logic  busy     [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic data_t mem_img(addr_t a);
        case (a)
            4'd0:    return 8'hB7;
            4'd2:    return 8'hE1;
            4'd5:    return 8'h5A;
            4'd6:    return 8'hC3;
            4'd9:    return 8'hE8;
            4'd15:   return 8'hFF;
            default: return {4'h1, a};
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(
            .WAIT_STATES ((g == 2) ? 2 : 0),
            .FETCH_PRIO  ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .f_req    (f_req[g]),
            .f_addr   (f_addr[g]),
            .f_gnt    (f_gnt[g]),
            .f_rvalid (f_rvalid[g]),
            .f_rdata  (f_rdata[g]),
            .d_req    (d_req[g]),
            .d_addr   (d_addr[g]),
            .d_gnt    (d_gnt[g]),
            .d_rvalid (d_rvalid[g]),
            .d_rdata  (d_rdata[g]),
            .d_lock   (d_lock[g]),
            .mem_addr (mem_addr[g]),
            .mem_data (mem_data[g]),
            .busy     (busy[g])
        );
        assign mem_data[g] = mem_img(mem_addr[g]);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            f_req[i]  = 1'b0;
            f_addr[i] = '0;
            d_req[i]  = 1'b0;
            d_addr[i] = '0;
            d_lock[i] = 1'b0;
        end

        // Reset values
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_f_gnt",    32'(f_gnt[i]), 0);
            check_eq("rst_d_gnt",    32'(d_gnt[i]), 0);
            check_eq("rst_f_rvalid", 32'(f_rvalid[i]), 0);
            check_eq("rst_d_rvalid", 32'(d_rvalid[i]), 0);
            check_eq("rst_f_rdata",  32'(f_rdata[i]), 0);
            check_eq("rst_d_rdata",  32'(d_rdata[i]), 0);
            check_eq("rst_mem_addr", 32'(mem_addr[i]), 0);
            check_eq("rst_busy",     32'(busy[i]), 0);
        end
        rst_n = 1'b1;
        step();

        // 1: single fetch, WAIT_STATES=0
        f_req[0] = 1'b1; f_addr[0] = 4'd0;
        #1;
        check_eq("t1_f_gnt", 32'(f_gnt[0]), 1);
        check_eq("t1_d_gnt", 32'(d_gnt[0]), 0);
        check_eq("t1_busy0", 32'(busy[0]), 0);
        step();
        f_req[0] = 1'b0;
        #1;
        check_eq("t1_mem_addr", 32'(mem_addr[0]), 0);
        check_eq("t1_busy1",    32'(busy[0]), 1);
        check_eq("t1_rv_early", 32'(f_rvalid[0]), 0);
        step();
        check_eq("t1_f_rvalid", 32'(f_rvalid[0]), 1);
        check_eq("t1_f_rdata",  32'(f_rdata[0]), 32'h B7);
        check_eq("t1_d_rvalid", 32'(d_rvalid[0]), 0);
        step();
        check_eq("t1_rv_pulse", 32'(f_rvalid[0]), 0);
        check_eq("t1_rdata_hold", 32'(f_rdata[0]), 32'h B7);

        // 2: round-robin conflict and back-to-back
        f_req[1] = 1'b1; f_addr[1] = 4'd2;
        d_req[1] = 1'b1; d_addr[1] = 4'd15;
        #1;
        check_eq("t2_f_gnt_first", 32'(f_gnt[1]), 1);
        check_eq("t2_d_gnt_first", 32'(d_gnt[1]), 0);
        step();
        f_req[1] = 1'b0;
        #1;
        check_eq("t2_mem_addr_f", 32'(mem_addr[1]), 2);
        check_eq("t2_no_gnt_acc", 32'(d_gnt[1]), 0);
        step();
        check_eq("t2_f_rvalid", 32'(f_rvalid[1]), 1);
        check_eq("t2_f_rdata",  32'(f_rdata[1]), 32'h E1);
        check_eq("t2_d_gnt_resp", 32'(d_gnt[1]), 1);
        step();
        d_req[1] = 1'b0;
        #1;
        check_eq("t2_mem_addr_d", 32'(mem_addr[1]), 15);
        step();
        check_eq("t2_d_rvalid", 32'(d_rvalid[1]), 1);
        check_eq("t2_d_rdata",  32'(d_rdata[1]), 32'h FF);
        check_eq("t2_f_rdata_kept", 32'(f_rdata[1]), 32'h E1);
        // last owner is debug: fetch wins this conflict
        f_req[1] = 1'b1; f_addr[1] = 4'd0;
        d_req[1] = 1'b1; d_addr[1] = 4'd9;
        #1;
        check_eq("t2_rr_f_gnt", 32'(f_gnt[1]), 1);
        check_eq("t2_rr_d_gnt", 32'(d_gnt[1]), 0);
        step();
        step();
        // last owner is fetch: debug wins, fetch keeps requesting
        check_eq("t2_rr2_f_rdata", 32'(f_rdata[1]), 32'h B7);
        check_eq("t2_rr2_d_gnt", 32'(d_gnt[1]), 1);
        check_eq("t2_rr2_f_gnt", 32'(f_gnt[1]), 0);
        step();
        d_req[1] = 1'b0;
        step();
        check_eq("t2_rr2_d_rdata", 32'(d_rdata[1]), 32'h E8);
        check_eq("t2_rr2_f_gnt_after", 32'(f_gnt[1]), 1);
        step();
        f_req[1] = 1'b0;
        step();
        check_eq("t2_rr2_f_rvalid", 32'(f_rvalid[1]), 1);
        step();

        // 3: fixed priority, fetch held continuously
        f_req[0] = 1'b1; f_addr[0] = 4'd0;
        d_req[0] = 1'b1; d_addr[0] = 4'd9;
        #1;
        for (int i = 0; i < 6; i++) begin
            check_eq("t3_d_starved", 32'(d_gnt[0]), 0);
            check_eq("t3_f_gnt", 32'(f_gnt[0]), (i % 2 == 0) ? 1 : 0);
            step();
        end
        f_req[0] = 1'b0;
        #1;
        check_eq("t3_d_gnt_release", 32'(d_gnt[0]), 1);
        check_eq("t3_f_gnt_release", 32'(f_gnt[0]), 0);
        step();
        d_req[0] = 1'b0;
        step();
        check_eq("t3_d_rvalid", 32'(d_rvalid[0]), 1);
        check_eq("t3_d_rdata",  32'(d_rdata[0]), 32'h E8);
        step();

        // 4: WAIT_STATES=2 debug read
        d_req[2] = 1'b1; d_addr[2] = 4'd9;
        #1;
        check_eq("t4_d_gnt", 32'(d_gnt[2]), 1);
        check_eq("t4_busy_gnt", 32'(busy[2]), 0);
        step();
        d_req[2] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check_eq("t4_busy", 32'(busy[2]), 1);
            check_eq("t4_mem_addr", 32'(mem_addr[2]), 9);
            check_eq("t4_no_rvalid", 32'(d_rvalid[2]), 0);
            step();
        end
        check_eq("t4_d_rvalid", 32'(d_rvalid[2]), 1);
        check_eq("t4_d_rdata",  32'(d_rdata[2]), 32'h E8);
        check_eq("t4_busy_resp", 32'(busy[2]), 0);
        step();
        check_eq("t4_rv_pulse", 32'(d_rvalid[2]), 0);

        // 5: reset in the middle of an access
        f_req[0] = 1'b1; f_addr[0] = 4'd6;
        #1;
        check_eq("t5_f_gnt", 32'(f_gnt[0]), 1);
        step();
        f_req[0] = 1'b0;
        #1;
        check_eq("t5_busy_pre", 32'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy_rst",     32'(busy[0]), 0);
        check_eq("t5_mem_addr_rst", 32'(mem_addr[0]), 0);
        check_eq("t5_f_rdata_rst",  32'(f_rdata[0]), 0);
        check_eq("t5_d_rdata_rst",  32'(d_rdata[0]), 0);
        check_eq("t5_f_rvalid_rst", 32'(f_rvalid[0]), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5_no_rvalid", 32'(f_rvalid[0]), 0);
        end
        f_req[0] = 1'b1; f_addr[0] = 4'd5;
        #1;
        check_eq("t5_regrant", 32'(f_gnt[0]), 1);
        step();
        f_req[0] = 1'b0;
        step();
        check_eq("t5_f_rvalid", 32'(f_rvalid[0]), 1);
        check_eq("t5_f_rdata",  32'(f_rdata[0]), 32'h 5A);
        step();

        // 6: debug lock (instance 1, round-robin)
        d_req[1] = 1'b1; d_addr[1] = 4'd5; d_lock[1] = 1'b1;
        #1;
        check_eq("t6_d_gnt0", 32'(d_gnt[1]), 1);
        step();
        f_req[1] = 1'b1; f_addr[1] = 4'd2;
        d_addr[1] = 4'd6;
        #1;
        check_eq("t6_f_gnt_acc", 32'(f_gnt[1]), 0);
        step();
        check_eq("t6_d_rdata0", 32'(d_rdata[1]), 32'h 5A);
`ifdef MEM_ARB_LOCK_EN
        check_eq("t6_lock_d_gnt", 32'(d_gnt[1]), 1);
        check_eq("t6_lock_f_gnt", 32'(f_gnt[1]), 0);
        step();
        d_req[1] = 1'b0; d_lock[1] = 1'b0;
        #1;
        check_eq("t6_lock_f_gnt_acc", 32'(f_gnt[1]), 0);
        step();
        check_eq("t6_lock_d_rdata1", 32'(d_rdata[1]), 32'h C3);
        check_eq("t6_unlock_f_gnt", 32'(f_gnt[1]), 1);
        step();
        f_req[1] = 1'b0;
        step();
        check_eq("t6_f_rdata", 32'(f_rdata[1]), 32'h E1);
`else
        check_eq("t6_nolock_f_gnt", 32'(f_gnt[1]), 1);
        check_eq("t6_nolock_d_gnt", 32'(d_gnt[1]), 0);
        step();
        f_req[1] = 1'b0; d_lock[1] = 1'b0;
        step();
        check_eq("t6_nolock_f_rdata", 32'(f_rdata[1]), 32'h E1);
        check_eq("t6_nolock_d_gnt2", 32'(d_gnt[1]), 1);
        step();
        d_req[1] = 1'b0;
        step();
        check_eq("t6_nolock_d_rdata1", 32'(d_rdata[1]), 32'h C3);
`endif
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single combinational program memory port (addr_t in, data_t out) between two requesters: the CPU instruction-fetch unit and a debug/inspection port.
- Owns the memory address bus, registers read data, and returns it to the granted requester with a one-cycle rvalid pulse.
- Sits between the fetch stage, the debug controller, and the memory instance.

Parameters:
- WAIT_STATES, 0, extra cycles the address is held before read data is sampled (0..3).
- FETCH_PRIO, 1, 1 = fetch always wins a conflict; 0 = two-way round-robin.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- f_req  input  1  fetch request; held until f_gnt
- f_addr  input  addr_t  fetch address (phys_addr 4 bits); stable while f_req
- f_gnt  output  1  fetch request accepted this cycle
- f_rvalid  output  1  one-cycle pulse: f_rdata valid
- f_rdata  output  data_t  fetch read data (raw_data 8 bits)
- d_req, d_addr, d_gnt, d_rvalid, d_rdata  same as f_* for the debug port
- d_lock  input  1  debug bus lock (see Optional Feature)
- mem_addr  output  addr_t  address to memory
- mem_data  input  data_t  memory read data (combinational from mem_addr)
- busy  output  1  access in flight (state ACCESS)

Behaviour:
- Reset values: all gnt and rvalid = 0; rdata = 0; mem_addr = 0; busy = 0; state IDLE; last_owner = DBG, so fetch wins the first round-robin conflict.
- States:
  - IDLE: no access in flight.
  - ACCESS: address driven; wait counter running.
  - RESP: rvalid cycle.
- Grant rule (IDLE or RESP):
  - Any req asserts its gnt combinationally in the same cycle.
  - On the gnt cycle the arbiter latches the requester's addr into mem_addr and the owner into a register.
  - Next state is ACCESS, with wait counter = WAIT_STATES.
  - Only one gnt is asserted per cycle.
- Conflict (both req):
  - FETCH_PRIO=1: fetch is granted.
  - FETCH_PRIO=0: the requester that is not last_owner is granted.
  - last_owner updates on every grant.
- ACCESS:
  - mem_addr is held; counter decrements each cycle.
  - When the counter reaches 0, mem_data is captured into the owner's rdata register and the state moves to RESP.
  - No gnt is asserted in ACCESS.
- RESP: the owner's rvalid = 1 for exactly this cycle. A new grant is permitted in the same cycle, which gives back-to-back accesses.
- Latency, req/gnt cycle N to rvalid: N + 2 + WAIT_STATES.
- Throughput: one access per (2 + WAIT_STATES) cycles.
- Requests:
  - Dropping req before gnt is legal and has no effect.
  - Changing addr while req is high and not yet granted is illegal; an assertion checks it.
- rdata of a port holds its value until that port's next response. The other port's rdata is never disturbed.
- mem_addr retains its last value in IDLE (no toggling).
- Reset asserted mid-ACCESS: immediate return to reset values; no rvalid is produced for the aborted access.
- No ACCESS→RESP event is lost: once granted, the response always completes unless reset intervenes.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - If d_lock = 1 on a debug grant, the arbiter enters locked mode.
  - In locked mode only d_req is granted; f_req waits with f_gnt = 0, regardless of FETCH_PRIO.
  - Locked mode ends at the first grant decision point (IDLE or RESP) where d_lock = 0. Fetch may be granted in that same cycle.
  - Reset clears the lock.
- Undefined: the d_lock port still exists (stable interface) but is ignored; there is no lock register.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - owner enum (OWN_FETCH, OWN_DBG)
  - WAIT_W width constant
- addr_t and data_t come from types.svh unchanged.
- Sub-module mem_arb_rr: 2-way round-robin/priority picker. Inputs: two requests, last_owner, FETCH_PRIO, lock. Outputs: one-hot grant. Purely combinational.

Test Plan:
1. Single fetch, WAIT_STATES=0, program image with mem[0]=0xB7: f_req with addr 0 at cycle 1.
   - f_gnt at cycle 1; mem_addr=0 from cycle 2; f_rvalid at cycle 3 with f_rdata=0xB7.
   - d_rvalid stays 0.
2. Conflict, FETCH_PRIO=0: both req at once, f_addr=2 (0xE1), d_addr=15 (0xFF).
   - Fetch granted first → f_rdata=0xE1.
   - Debug granted in the RESP cycle → d_rdata=0xFF two cycles later; no idle gap.
3. FETCH_PRIO=1 starvation check: f_req held continuously, d_req held.
   - d_gnt never asserts while f_req=1.
   - d_gnt asserts in the first decision cycle after f_req drops.
4. WAIT_STATES=2: debug read of addr 9 (0xE8).
   - d_rvalid exactly 4 cycles after d_gnt; busy high for 3 cycles; mem_addr stable=9 throughout.
5. Reset mid-ACCESS: deassert rst_n one cycle after f_gnt.
   - All outputs return to 0 asynchronously; no f_rvalid after release; next request served normally.
6. MEM_ARB_LOCK_EN: d_lock=1 with debug reads of addr 5 then 6 while f_req=1.
   - Both debug reads complete back-to-back, with f_gnt=0 throughout.
   - After d_lock drops, fetch is granted at the next decision cycle.
   - Without the macro, fetch interleaves.
